p_wupdate: RTL and testbench

//  Backward-pass counterpart of the forward accumulator.
//  - The accumulator reduces an IN-wide vector to one scalar. This block takes one scalar error and

---
 rtl/p_wupdate_pkg.sv | 39 +++
 rtl/p_wupd_lane.sv | 61 ++++++
 rtl/p_wupdate.sv | 147 ++++++++++++++
 tb/tb_p_wupdate.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/p_wupdate_pkg.sv
// Shared types for the perceptron weight-update block: data configuration,
// FSM state encoding and small elaboration-time helpers.
package p_wupdate_pkg;

    typedef enum logic [1:0] {
        DT_INT  = 2'd0,
        DT_FXP  = 2'd1,
        DT_BOOL = 2'd2,
        DT_FP   = 2'd3
    } dtype_t;

    typedef struct packed {
        dtype_t      dtype;
        logic [15:0] prec;
        logic [15:0] frac;
    } dconf_t;

    localparam dconf_t DEF_DCONF = '{dtype: DT_INT, prec: 16'd8, frac: 16'd0};

    typedef enum logic [1:0] {
        WU_IDLE = 2'd0,
        WU_CALC = 2'd1,
        WU_DONE = 2'd2
    } wupd_state_t;

    // Lane index width; a single-lane node still needs a 1-bit counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wu_sat_max(input int prec);
        return (2 ** (prec - 1)) - 1;
    endfunction

    function automatic int wu_sat_min(input int prec);
        return -(2 ** (prec - 1));
    endfunction

endpackage

// File: rtl/p_wupd_lane.sv
// Combinational single-lane update: w_new = sat(w + ((err*x) >>> lr_shift)),
// with optional fixed-point rescale (round-half-up) when F > 0.
module p_wupd_lane #(
    parameter int P   = 8,
    parameter int F   = 0,
    parameter int SHW = 4
) (
    input  logic signed [P-1:0]   err,
    input  logic signed [P-1:0]   x_i,
    input  logic signed [P-1:0]   w_i,
    input  logic        [SHW-1:0] lr_shift,
    output logic signed [P-1:0]   w_new,
    output logic                  ovf,
    output logic                  udf,
    output logic                  rounded
);

    // Two guard bits above the full product keep the rounding add and the
    // weight add free of wrap-around.
    localparam int W = 2 * P + 2;
    localparam logic signed [W-1:0] SMAX = {{(W - P + 1){1'b0}}, {(P - 1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {{(W - P + 1){1'b1}}, {(P - 1){1'b0}}};

    logic signed [2*P-1:0] p;
    logic signed [W-1:0]   pe;
    logic signed [W-1:0]   pr;
    logic signed [W-1:0]   d;
    logic signed [W-1:0]   s;

    assign p  = (2*P)'(err) * (2*P)'(x_i);
    assign pe = {{(W - 2 * P){p[2*P-1]}}, p};

    generate
        if (F > 0) begin : g_rnd
            localparam logic signed [W-1:0] HALF = W'(2 ** (F - 1));
            // Adding half then flooring gives round-half-up for both signs.
            assign pr      = (pe + HALF) >>> F;
            assign rounded = (p[F-1:0] != '0);
        end else begin : g_nornd
            assign pr      = pe;
            assign rounded = 1'b0;
        end
    endgenerate

    assign d   = pr >>> lr_shift;
    assign udf = (p != '0) && (d == '0);
    assign s   = {{(W - P){w_i[P-1]}}, w_i} + d;

    always_comb begin
        ovf   = 1'b0;
        w_new = P'(s);
        if (s > SMAX) begin
            w_new = P'(SMAX);
            ovf   = 1'b1;
        end else if (s < SMIN) begin
            w_new = P'(SMIN);
            ovf   = 1'b1;
        end
    end

endmodule

// File: rtl/p_wupdate.sv
// Perceptron weight update: latches one error scalar plus input/weight vectors
// and rewrites one weight lane per cycle through a shared lane datapath.
//
// state   | meaning
// WU_IDLE | ready=1, waiting for start; latches job on accept
// WU_CALC | one lane per cycle, idx 0..IN-1 written into w_out
// WU_DONE | one-cycle done pulse, then back to idle
module p_wupdate
    import p_wupdate_pkg::*;
#(
    parameter int     IN   = 8,
    parameter dconf_t CONF = DEF_DCONF,
    parameter int     SHW  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      ready,
    input  logic [SHW-1:0]            lr_shift,
    input  logic [CONF.prec-1:0]      err,
    input  logic [IN*CONF.prec-1:0]   x,
    input  logic [IN*CONF.prec-1:0]   w_in,
    output logic [IN*CONF.prec-1:0]   w_out,
    output logic                      done,
    output logic                      ovf,
    output logic                      udf,
    output logic                      rounded
);

    localparam int P  = int'(CONF.prec);
    localparam int F  = int'(CONF.frac);
    localparam int IW = idx_width(IN);
    localparam logic [IW-1:0] LAST = IW'(IN - 1);

    wupd_state_t state, state_nx;

    logic [IW-1:0]   idx;
    logic [P-1:0]    err_q;
    logic [IN*P-1:0] x_q;
    logic [IN*P-1:0] w_q;
    logic [SHW-1:0]  lr_q;

    logic              accept;
    logic              last;
    logic signed [P-1:0] x_sel;
    logic signed [P-1:0] w_sel;
    logic signed [P-1:0] lane_w;
    logic              lane_ovf;
    logic              lane_udf;
    logic              lane_rnd;

    assign accept = ready & start;
    assign last   = (idx == LAST);
    assign x_sel  = x_q[idx*P +: P];
    assign w_sel  = w_q[idx*P +: P];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WU_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        done     = 1'b0;
        case (state)
            WU_IDLE: begin
                ready = 1'b1;
                if (start) state_nx = WU_CALC;
            end
            WU_CALC: begin
                if (last) state_nx = WU_DONE;
            end
            WU_DONE: begin
                done     = 1'b1;
                state_nx = WU_IDLE;
            end
            default: state_nx = WU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            err_q   <= '0;
            x_q     <= '0;
            w_q     <= '0;
            lr_q    <= '0;
            w_out   <= '0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
            rounded <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            err_q   <= err;
            x_q     <= x;
            w_q     <= w_in;
            lr_q    <= lr_shift;
            ovf     <= 1'b0;
            udf     <= 1'b0;
            rounded <= 1'b0;
        end else if (state == WU_CALC) begin
            w_out[idx*P +: P] <= lane_w;
            ovf     <= ovf | lane_ovf;
            udf     <= udf | lane_udf;
            rounded <= rounded | lane_rnd;
            idx     <= last ? '0 : idx + 1'b1;
        end
    end

    // Only integer and fixed-point arithmetic exist; other types pass weights through.
    generate
        case (CONF.dtype)
            DT_INT: begin : g_int
                p_wupd_lane #(.P(P), .F(0), .SHW(SHW)) u_lane (
                    .err      (err_q),
                    .x_i      (x_sel),
                    .w_i      (w_sel),
                    .lr_shift (lr_q),
                    .w_new    (lane_w),
                    .ovf      (lane_ovf),
                    .udf      (lane_udf),
                    .rounded  (lane_rnd)
                );
            end
            DT_FXP: begin : g_fxp
                p_wupd_lane #(.P(P), .F(F), .SHW(SHW)) u_lane (
                    .err      (err_q),
                    .x_i      (x_sel),
                    .w_i      (w_sel),
                    .lr_shift (lr_q),
                    .w_new    (lane_w),
                    .ovf      (lane_ovf),
                    .udf      (lane_udf),
                    .rounded  (lane_rnd)
                );
            end
            default: begin : g_unimpl
                assign lane_w   = w_sel;
                assign lane_ovf = 1'b0;
                assign lane_udf = 1'b0;
                assign lane_rnd = 1'b0;
            end
        endcase
    endgenerate

endmodule

// File: tb/tb_p_wupdate.sv
// Directed bench for p_wupdate: an INT and an FXP instance share stimulus,
// expected values are hand-computed constants.
module tb_p_wupdate;
    import p_wupdate_pkg::*;

    localparam int     IN = 4;
    localparam dconf_t CI = '{dtype: DT_INT, prec: 16'd8, frac: 16'd0};
    localparam dconf_t CF = '{dtype: DT_FXP, prec: 16'd8, frac: 16'd4};

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  lr_shift;
    logic [7:0]  err;
    logic [31:0] x;
    logic [31:0] w_in;

    logic        ready_i, done_i, ovf_i, udf_i, rnd_i;
    logic [31:0] w_out_i;
    logic        ready_f, done_f, ovf_f, udf_f, rnd_f;
    logic [31:0] w_out_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    p_wupdate #(.IN(IN), .CONF(CI), .SHW(4)) dut_i (
        .clk(clk), .reset(reset), .start(start), .ready(ready_i),
        .lr_shift(lr_shift), .err(err), .x(x), .w_in(w_in), .w_out(w_out_i),
        .done(done_i), .ovf(ovf_i), .udf(udf_i), .rounded(rnd_i)
    );

    p_wupdate #(.IN(IN), .CONF(CF), .SHW(4)) dut_f (
        .clk(clk), .reset(reset), .start(start), .ready(ready_f),
        .lr_shift(lr_shift), .err(err), .x(x), .w_in(w_in), .w_out(w_out_f),
        .done(done_f), .ovf(ovf_f), .udf(udf_f), .rounded(rnd_f)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // lane 0 sits in the least significant byte
    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Accepts one job, scrambles the ports afterwards and waits for done.
    task automatic run_job(input string tag, input logic [7:0] e, input logic [31:0] xv,
                           input logic [31:0] wv, input logic [3:0] lr);
        int n;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(ready_i), 32'd1);
        err = e; x = xv; w_in = wv; lr_shift = lr; start = 1'b1;
        @(negedge clk);
        start = 1'b0; err = 8'h55; x = 32'hFFFF_FFFF; w_in = 32'h7F7F_7F7F; lr_shift = 4'hF;
        n = 1;
        while (!done_i && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd5);
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        chk({tag, "_ready_after"}, {30'd0, ready_i, done_i}, 32'b10);
    endtask

    initial begin
        int ndone;
        reset = 1'b1; start = 1'b0; lr_shift = '0; err = '0; x = '0; w_in = '0;
        #1;
        chk("rst_ready", {30'd0, ready_i, ready_f}, 32'b11);
        chk("rst_done", {30'd0, done_i, done_f}, 32'b00);
        chk("rst_wout_i", w_out_i, 32'd0);
        chk("rst_wout_f", w_out_f, 32'd0);
        chk("rst_flags", {26'd0, ovf_i, udf_i, rnd_i, ovf_f, udf_f, rnd_f}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: plain INT update
        run_job("s1", 8'd2, pk(1, -1, 3, 0), pk(10, 10, 10, 10), 4'd0);
        chk("s1_wout", w_out_i, pk(12, 8, 16, 10));
        chk("s1_flags", {29'd0, ovf_i, udf_i, rnd_i}, 32'b000);
        after_done("s1");

        // 2: saturation both ways
        run_job("s2", 8'd100, pk(2, -2, 0, 0), pk(100, -100, 0, 0), 4'd0);
        chk("s2_wout", w_out_i, pk(127, -128, 0, 0));
        chk("s2_flags", {29'd0, ovf_i, udf_i, rnd_i}, 32'b100);
        after_done("s2");

        // 3: learning-rate shift underflows a nonzero product
        run_job("s3", 8'd1, pk(1, 0, 0, 0), pk(0, 0, 0, 0), 4'd3);
        chk("s3_wout", w_out_i, 32'd0);
        chk("s3_flags", {29'd0, ovf_i, udf_i, rnd_i}, 32'b010);
        after_done("s3");

        // 4: FXP rounding 1.5*1.0625 -> 0x1A; INT instance saturates the same raw product
        run_job("s4", 8'h18, pk(17, 0, 0, 0), pk(0, 0, 0, 0), 4'd0);
        chk("s4_fxp_wout", w_out_f, pk(26, 0, 0, 0));
        chk("s4_fxp_flags", {29'd0, ovf_f, udf_f, rnd_f}, 32'b001);
        chk("s4_fxp_done", 32'(done_f), 32'd1);
        chk("s4_int_wout", w_out_i, pk(127, 0, 0, 0));
        chk("s4_int_flags", {29'd0, ovf_i, udf_i, rnd_i}, 32'b100);
        after_done("s4");

        // 7: maximum shift, negative product keeps -1, positive product vanishes
        run_job("s7", 8'hFF, pk(1, -1, 0, 0), pk(5, 5, 5, 5), 4'd15);
        chk("s7_wout", w_out_i, pk(4, 5, 5, 5));
        chk("s7_flags", {29'd0, ovf_i, udf_i, rnd_i}, 32'b010);
        after_done("s7");

        // 5: start pulses during a busy job are ignored
        @(negedge clk);
        err = 8'd2; x = pk(1, -1, 3, 0); w_in = pk(10, 10, 10, 10); lr_shift = 4'd0; start = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("s5_ready", 32'(ready_i), (k >= 6) ? 32'd1 : 32'd0);
            chk("s5_done", 32'(done_i), (k == 5) ? 32'd1 : 32'd0);
            if (done_i) ndone++;
            start = (k == 2 || k == 4);
            if (start) begin
                err = 8'h7F; x = pk(3, 3, 3, 3); w_in = pk(1, 1, 1, 1); lr_shift = 4'd1;
            end
        end
        chk("s5_ndone", 32'(ndone), 32'd1);
        chk("s5_wout", w_out_i, pk(12, 8, 16, 10));

        // 6: reset in the middle of a job
        w_in = pk(0, 0, 0, 0);
        @(negedge clk);
        err = 8'd2; x = pk(1, -1, 3, 0); w_in = pk(10, 10, 10, 10); lr_shift = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("s6_partial", {24'd0, w_out_i[7:0]}, 32'd12);
        reset = 1'b1;
        #1;
        chk("s6_rst_ready", 32'(ready_i), 32'd1);
        chk("s6_rst_wout", w_out_i, 32'd0);
        chk("s6_rst_done", 32'(done_i), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_i || !ready_i) ndone++;
        end
        chk("s6_quiet", 32'(ndone), 32'd0);
        run_job("s6b", 8'd2, pk(1, -1, 3, 0), pk(10, 10, 10, 10), 4'd0);
        chk("s6b_wout", w_out_i, pk(12, 8, 16, 10));
        chk("s6b_flags", {29'd0, ovf_i, udf_i, rnd_i}, 32'b000);
        after_done("s6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
